// File: rtl/i2c_scl_timing_gen.sv
// i2c_scl_timing_gen: programmable SCL bit-timing engine with stretching, clock sync and bit timeout
module i2c_scl_timing_gen #(
  parameter int PERIOD_W    = 16,
  parameter int NBITS_W     = 8,
  parameter int TIMEOUT_W   = 28,
  parameter int MIN_QUARTER = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 start_i,
  input  logic [PERIOD_W-1:0]  period_i,
  input  logic [NBITS_W-1:0]   nbits_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 stop_req_i,
  input  logic                 scl_i,
  output logic                 scl_oe_o,
  output logic [3:0]           q_tick_o,
  output logic                 bit_done_o,
  output logic                 busy_o,
  output logic                 stretch_o,
  output logic [TIMEOUT_W-1:0] stretch_cnt_o,
  output logic [7:0]           sync_cnt_o,
  output logic                 timeout_o
);
  typedef enum logic [2:0] {IDLE, LOW_A, LOW_B, RISE, HIGH_A, HIGH_B} state_e;
  localparam logic [PERIOD_W-1:0] QMIN = PERIOD_W'(MIN_QUARTER);
  state_e               state_q, state_d;
  logic [PERIOD_W-1:0]  q_len_q, q_len_d, cnt_q, cnt_d, q_new;
  logic [NBITS_W-1:0]   bits_q, bits_d;
  logic [TIMEOUT_W-1:0] st_q, st_d, st_len_q, st_len_d, st_nx;
  logic [7:0]           sync_q, sync_d, sync_inc;
  logic                 stop_q, stop_d, to_q, to_d, last;
  always_comb begin
    q_new    = (period_i >> 2) < QMIN ? QMIN : period_i >> 2;
    last     = cnt_q == q_len_q - 1'b1;
    st_nx    = (scl_i || &st_q) ? st_q : st_q + 1'b1;
    sync_inc = sync_q + (&sync_q ? 8'd0 : 8'd1);
    state_d  = state_q;
    q_len_d  = q_len_q;
    bits_d   = bits_q;
    st_d     = st_q;
    st_len_d = st_len_q;
    sync_d   = sync_q;
    to_d     = to_q;
    stop_d   = stop_q | (stop_req_i & (state_q != IDLE));
    case (state_q)
      IDLE: if (start_i && nbits_i != '0) begin
        state_d = LOW_A;
        q_len_d = q_new;
        bits_d  = nbits_i;
        to_d    = 1'b0;
      end
      LOW_A: state_d = last ? LOW_B : LOW_A;
      LOW_B: begin
        state_d = last ? RISE : LOW_B;
        st_d    = last ? '0 : st_q;
      end
      RISE: begin
        st_d = st_nx;
        if (timeout_i != '0 && st_nx == timeout_i) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else if (scl_i) begin
          st_len_d = st_q;
          state_d  = HIGH_A;
        end
      end
      HIGH_A: if (!scl_i) begin
        state_d = LOW_A;
        sync_d  = sync_inc;
      end else if (last) state_d = HIGH_B;
      HIGH_B: if (!scl_i) begin
        state_d = LOW_A;
        sync_d  = sync_inc;
      end else if (last) begin
        bits_d  = bits_q - 1'b1;
        state_d = (bits_q == NBITS_W'(1) || stop_q || stop_req_i) ? IDLE : LOW_A;
      end
      default: state_d = IDLE;
    endcase
    stop_d = state_d == IDLE ? 1'b0 : stop_d;
    cnt_d  = state_d != state_q ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q  <= IDLE;
      q_len_q  <= '0;
      cnt_q    <= '0;
      bits_q   <= '0;
      st_q     <= '0;
      st_len_q <= '0;
      sync_q   <= '0;
      stop_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_len_q  <= q_len_d;
      cnt_q    <= cnt_d;
      bits_q   <= bits_d;
      st_q     <= st_d;
      st_len_q <= st_len_d;
      sync_q   <= sync_d;
      stop_q   <= stop_d;
      to_q     <= to_d;
    end
  end
  assign scl_oe_o      = state_q == LOW_A || state_q == LOW_B;
  assign q_tick_o      = cnt_q == '0 ? {state_q == HIGH_B, state_q == HIGH_A, state_q == LOW_B, state_q == LOW_A} : 4'b0;
  assign bit_done_o    = state_q == HIGH_B && last && scl_i;
  assign busy_o        = state_q != IDLE;
  assign stretch_o     = state_q == RISE && !scl_i;
  assign stretch_cnt_o = st_len_q;
  assign sync_cnt_o    = sync_q;
  assign timeout_o     = to_q;
endmodule

// File: tb/tb_i2c_scl_timing_gen.sv
// tb_i2c_scl_timing_gen: scoreboard bench checking bit_done timing and SCL phase behaviour
`timescale 1ns/1ps
module tb_i2c_scl_timing_gen;
  logic        wb_clk_i = 0, wb_rst_ni = 0, start_i = 0, stop_req_i = 0, ext_low = 0;
  logic [15:0] period_i = 0;
  logic [7:0]  nbits_i = 0;
  logic [27:0] timeout_i = 0;
  logic        scl_i, scl_oe_o, bit_done_o, busy_o, stretch_o, timeout_o;
  logic [3:0]  q_tick_o;
  logic [27:0] stretch_cnt_o;
  logic [7:0]  sync_cnt_o;
  int cyc = 0, checks = 0, failures = 0, oe_n = 0, st_n = 0;
  int qt_n [4] = '{0, 0, 0, 0};
  int exp_q [$];
  assign scl_i = ~scl_oe_o & ~ext_low;
  i2c_scl_timing_gen dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .start_i(start_i), .period_i(period_i),
    .nbits_i(nbits_i), .timeout_i(timeout_i), .stop_req_i(stop_req_i), .scl_i(scl_i),
    .scl_oe_o(scl_oe_o), .q_tick_o(q_tick_o), .bit_done_o(bit_done_o), .busy_o(busy_o),
    .stretch_o(stretch_o), .stretch_cnt_o(stretch_cnt_o), .sync_cnt_o(sync_cnt_o),
    .timeout_o(timeout_o)
  );
  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  always @(negedge wb_clk_i) begin
    if (scl_oe_o) oe_n <= oe_n + 1;
    if (stretch_o) st_n <= st_n + 1;
    for (int i = 0; i < 4; i++) if (q_tick_o[i]) qt_n[i] <= qt_n[i] + 1;
    if (bit_done_o) begin
      if (exp_q.size() == 0) chk("unexpected_bit_done", cyc, -1);
      else chk("bit_done_cycle", cyc, exp_q.pop_front());
    end
  end
  function automatic int qlen(input int p);
    return (p / 4 < 2) ? 2 : p / 4;
  endfunction
  task automatic tick_to(input int c);
    while (cyc < c) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask
  task automatic start(input int p, input int n, input int to, output int e);
    @(posedge wb_clk_i);
    #1;
    period_i  = 16'(p);
    nbits_i   = 8'(n);
    timeout_i = 28'(to);
    start_i   = 1;
    @(posedge wb_clk_i);
    #1;
    start_i = 0;
    e = cyc;
  endtask
  task automatic wait_idle(input int budget, output int t);
    int n = 0;
    while (busy_o && n < budget) begin
      @(posedge wb_clk_i);
      #1;
      n++;
    end
    t = cyc;
    chk("idle_within_budget", int'(busy_o), 0);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask
  function automatic int outs_or();
    return int'({scl_oe_o, q_tick_o, bit_done_o, busy_o, stretch_o, timeout_o}) | int'(sync_cnt_o) | int'(stretch_cnt_o);
  endfunction
  initial begin
    int e, t, q, b_oe, b_st;
    int b_qt [4];
    tick_to(3);
    chk("reset_outputs", outs_or(), 0);
    wb_rst_ni = 1;
    b_oe = oe_n;
    b_qt = qt_n;
    q = qlen(230);
    start(230, 9, 0, e);
    for (int k = 0; k < 9; k++) exp_q.push_back(e + 4 * q + k * (4 * q + 1));
    chk("latency_oe", int'(scl_oe_o), 1);
    chk("latency_qtick", int'(q_tick_o), 1);
    chk("busy_high", int'(busy_o), 1);
    wait_idle(3000, t);
    chk("basic_busy_fall", t, e + 4 * q + 8 * (4 * q + 1) + 1);
    chk("basic_oe_cycles", oe_n - b_oe, 9 * 114);
    for (int i = 0; i < 4; i++) chk("basic_qtick_count", qt_n[i] - b_qt[i], 9);
    b_oe = oe_n;
    start(4, 2, 0, e);
    exp_q.push_back(e + 8);
    exp_q.push_back(e + 17);
    wait_idle(100, t);
    chk("clamp_busy_fall", t, e + 18);
    chk("clamp_oe_cycles", oe_n - b_oe, 8);
    b_st = st_n;
    start(230, 1, 0, e);
    exp_q.push_back(e + 456);
    tick_to(e + 100);
    ext_low = 1;
    tick_to(e + 342);
    ext_low = 0;
    wait_idle(1000, t);
    chk("stretch_cycles", st_n - b_st, 228);
    chk("stretch_cnt", int'(stretch_cnt_o), 228);
    ext_low = 1;
    start(230, 3, 1000, e);
    tick_to(e + 1113);
    chk("timeout_not_yet", int'(timeout_o), 0);
    chk("timeout_busy_before", int'(busy_o), 1);
    wait_idle(200, t);
    chk("timeout_fall_cycle", t, e + 1114);
    chk("timeout_set", int'(timeout_o), 1);
    chk("timeout_keeps_stretch_cnt", int'(stretch_cnt_o), 228);
    start(230, 0, 0, e);
    tick_to(e + 2);
    chk("nbits0_not_busy", int'(busy_o), 0);
    chk("nbits0_keeps_timeout", int'(timeout_o), 1);
    ext_low = 0;
    start(4, 1, 0, e);
    exp_q.push_back(e + 8);
    chk("start_clears_timeout", int'(timeout_o), 0);
    wait_idle(100, t);
    chk("sync_before", int'(sync_cnt_o), 0);
    start(230, 3, 0, e);
    exp_q.push_back(e + 354);
    exp_q.push_back(e + 583);
    exp_q.push_back(e + 812);
    tick_to(e + 125);
    ext_low = 1;
    tick_to(e + 126);
    chk("sync_relow", int'(scl_oe_o), 1);
    chk("sync_qtick0", int'(q_tick_o), 1);
    tick_to(e + 130);
    ext_low = 0;
    wait_idle(2000, t);
    chk("sync_cnt", int'(sync_cnt_o), 1);
    start(4, 9, 0, e);
    exp_q.push_back(e + 8);
    exp_q.push_back(e + 17);
    tick_to(e + 12);
    stop_req_i = 1;
    tick_to(e + 13);
    stop_req_i = 0;
    wait_idle(200, t);
    chk("stop_busy_fall", t, e + 18);
    start(230, 4, 0, e);
    tick_to(e + 70);
    chk("lowb_driving", int'(scl_oe_o), 1);
    wb_rst_ni = 0;
    tick_to(e + 71);
    chk("midburst_reset_outputs", outs_or(), 0);
    tick_to(e + 73);
    wb_rst_ni = 1;
    tick_to(e + 80);
    chk("post_reset_idle", int'(busy_o), 0);
    chk("post_reset_no_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d expected completion earlier", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
